// File: rtl/mips_fdx_frontend.sv
// Fetch, decode and execute stages of the 5-stage MIPS pipeline, including the D/X register.
// Optional REGFILE_WRITE_THROUGH_EN: decode reads see the writeback data written in the same cycle.
module mips_fdx_frontend #(
  parameter logic [31:0] BASE_ADDR = 32'h80020000,
  parameter logic [31:0] SP_INIT   = 32'h80120000,
  parameter logic [31:0] RA_INIT   = 32'hdeadbeef
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic        i_mem_enable,
  output logic        i_rw,
  output logic [1:0]  i_access_size,
  input  logic [31:0] insn,
  input  logic        stall,
  output logic [31:0] pc_fd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] mx_data,
  input  logic [31:0] wx_data,
  input  logic        byp_mx_a,
  input  logic        byp_wx_a,
  input  logic        byp_mx_b,
  input  logic        byp_wx_b,
  output logic [31:0] ir_dx,
  output logic [7:0]  ctl_dx,
  output logic [31:0] alu_out,
  output logic [31:0] rb_out,
  output logic [31:0] pc_effective,
  output logic        do_branch
);

  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI   = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI    = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111, OP_LB     = 6'b100000, OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000, OP_SW     = 6'b101011;

  // ALU opcodes reuse the R-type funct encoding; LUI and link get private codes.
  localparam logic [5:0] ALU_SLL  = 6'b000000, ALU_SRL  = 6'b000010, ALU_SRA  = 6'b000011;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] ALU_ADD  = 6'b100000, ALU_ADDU = 6'b100001, ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_SUBU = 6'b100011, ALU_AND  = 6'b100100, ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110, ALU_NOR  = 6'b100111, ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011, ALU_LUI  = 6'b111110, ALU_LINK = 6'b111111;
  localparam logic [5:0] ALU_NOP  = ALU_ADDU;

  logic [31:0] regs [NREG];
  logic [31:0] ra_d, rb_d;
  logic [7:0]  ctl_d;
  logic [5:0]  aluop_d;
  logic [31:0] pc_dx, ra_dx, rb_dx;
  logic [5:0]  aluop_dx;

  assign i_address     = pc_fd;
  assign i_mem_enable  = ~reset;
  assign i_rw          = 1'b1;
  assign i_access_size = 2'b00;

  // Fetch: taken branch/jump redirects ahead of a load-use stall.
  always_ff @(posedge clock) begin
    if (reset)          pc_fd <= BASE_ADDR;
    else if (do_branch) pc_fd <= pc_effective;
    else if (!stall)    pc_fd <= pc_fd + 32'd4;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : 32'd0;
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    ra_d = (insn[25:21] == 5'd0) ? 32'd0 : regs[insn[25:21]];
    rb_d = (insn[20:16] == 5'd0) ? 32'd0 : regs[insn[20:16]];
`ifdef REGFILE_WRITE_THROUGH_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == insn[25:21]) ra_d = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == insn[20:16]) rb_d = wb_data;
`endif
  end

  // Decode: ctl = {br,jp,aluinb,dmwe,rwe,rdst,rwd,dm_byte}; unknown encodings stay all-zero.
  always_comb begin
    ctl_d   = 8'd0;
    aluop_d = ALU_NOP;
    case (insn[31:26])
      OP_RTYPE: begin
        case (insn[5:0])
          ALU_ADDU, ALU_ADD, ALU_SUBU, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
          ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA: begin
            ctl_d   = 8'b0000_1100;
            aluop_d = insn[5:0];
          end
          F_JR:    ctl_d = 8'b0100_0000;
          default: ;
        endcase
      end
      OP_REGIMM: if (insn[20:17] == 4'd0) ctl_d = 8'b1000_0000;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctl_d = 8'b1000_0000;
      OP_J:   ctl_d = 8'b0100_0000;
      OP_JAL: begin ctl_d = 8'b0100_1000; aluop_d = ALU_LINK; end
      OP_ADDI, OP_ADDIU: ctl_d = 8'b0010_1000;
      OP_SLTI:  begin ctl_d = 8'b0010_1000; aluop_d = ALU_SLT;  end
      OP_SLTIU: begin ctl_d = 8'b0010_1000; aluop_d = ALU_SLTU; end
      OP_ANDI:  begin ctl_d = 8'b0010_1000; aluop_d = ALU_AND;  end
      OP_ORI:   begin ctl_d = 8'b0010_1000; aluop_d = ALU_OR;   end
      OP_XORI:  begin ctl_d = 8'b0010_1000; aluop_d = ALU_XOR;  end
      OP_LUI:   begin ctl_d = 8'b0010_1000; aluop_d = ALU_LUI;  end
      OP_LW:    ctl_d = 8'b0010_1010;
      OP_LB:    ctl_d = 8'b0010_1011;
      OP_SW:    ctl_d = 8'b0011_0000;
      OP_SB:    ctl_d = 8'b0011_0001;
      default:  ;
    endcase
  end

  // D/X register; stalls and redirects insert a bubble.
  always_ff @(posedge clock) begin
    if (reset || stall || do_branch) begin
      pc_dx    <= 32'd0;
      ir_dx    <= 32'd0;
      ra_dx    <= 32'd0;
      rb_dx    <= 32'd0;
      ctl_dx   <= 8'd0;
      aluop_dx <= ALU_NOP;
    end else begin
      pc_dx    <= pc_fd;
      ir_dx    <= insn;
      ra_dx    <= ra_d;
      rb_dx    <= rb_d;
      ctl_dx   <= ctl_d;
      aluop_dx <= aluop_d;
    end
  end

  logic [31:0] op_a, op_b, imm_ext, alu_b, br_target;
  logic [15:0] imm16;
  logic [4:0]  shamt;
  logic        br_taken;

  always_comb begin
    op_a    = byp_mx_a ? mx_data : byp_wx_a ? wx_data : ra_dx;
    op_b    = byp_mx_b ? mx_data : byp_wx_b ? wx_data : rb_dx;
    imm16   = ir_dx[15:0];
    shamt   = ir_dx[10:6];
    imm_ext = (ir_dx[31:26] == OP_ANDI || ir_dx[31:26] == OP_ORI || ir_dx[31:26] == OP_XORI)
              ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};
    alu_b   = ctl_dx[5] ? imm_ext : op_b;
    rb_out  = op_b;
    case (aluop_dx)
      ALU_ADD, ALU_ADDU: alu_out = op_a + alu_b;
      ALU_SUB, ALU_SUBU: alu_out = op_a - alu_b;
      ALU_AND:  alu_out = op_a & alu_b;
      ALU_OR:   alu_out = op_a | alu_b;
      ALU_XOR:  alu_out = op_a ^ alu_b;
      ALU_NOR:  alu_out = ~(op_a | alu_b);
      ALU_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {31'd0, op_a < alu_b};
      ALU_SLL:  alu_out = alu_b << shamt;
      ALU_SRL:  alu_out = alu_b >> shamt;
      ALU_SRA:  alu_out = 32'($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_out = {imm16, 16'd0};
      ALU_LINK: alu_out = pc_dx + 32'd8;
      default:  alu_out = op_a + alu_b;
    endcase
  end

  // Branch/jump resolution; conditions compare signed operands after bypass.
  always_comb begin
    br_target = pc_dx + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    case (ir_dx[31:26])
      OP_BEQ:    br_taken = (op_a == op_b);
      OP_BNE:    br_taken = (op_a != op_b);
      OP_BLEZ:   br_taken = ($signed(op_a) <= 0);
      OP_BGTZ:   br_taken = ($signed(op_a) > 0);
      OP_REGIMM: br_taken = ir_dx[16] ? ($signed(op_a) >= 0) : ($signed(op_a) < 0);
      default:   br_taken = 1'b0;
    endcase
    if (ctl_dx[6])
      pc_effective = (ir_dx[31:26] == OP_RTYPE) ? op_a : {pc_dx[31:28], ir_dx[25:0], 2'b00};
    else
      pc_effective = br_target;
    do_branch = ~reset & (ctl_dx[6] | (ctl_dx[7] & br_taken));
  end

endmodule

// File: tb/tb_mips_fdx_frontend.sv
// Directed self-checking bench for mips_fdx_frontend with hand-computed expectations.
module tb_mips_fdx_frontend;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_mem_enable, i_rw;
  logic [1:0]  i_access_size;
  logic [31:0] insn;
  logic        stall;
  logic [31:0] pc_fd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, mx_data, wx_data;
  logic        byp_mx_a, byp_wx_a, byp_mx_b, byp_wx_b;
  logic [31:0] ir_dx;
  logic [7:0]  ctl_dx;
  logic [31:0] alu_out, rb_out, pc_effective;
  logic        do_branch;

  int n_tests = 0;
  int n_fail  = 0;

  mips_fdx_frontend dut (
    .clock(clock), .reset(reset), .i_address(i_address), .i_mem_enable(i_mem_enable),
    .i_rw(i_rw), .i_access_size(i_access_size), .insn(insn), .stall(stall), .pc_fd(pc_fd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mx_data(mx_data), .wx_data(wx_data),
    .byp_mx_a(byp_mx_a), .byp_wx_a(byp_wx_a), .byp_mx_b(byp_mx_b), .byp_wx_b(byp_wx_b),
    .ir_dx(ir_dx), .ctl_dx(ctl_dx), .alu_out(alu_out), .rb_out(rb_out),
    .pc_effective(pc_effective), .do_branch(do_branch)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_byp();
    byp_mx_a = 0; byp_wx_a = 0; byp_mx_b = 0; byp_wx_b = 0;
    mx_data = 0; wx_data = 0;
  endtask

  task automatic do_reset();
    reset = 1; insn = 0; stall = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    clear_byp();
    tick();
    tick();
    reset = 0;
  endtask

  logic [31:0] addiu_r2_5;
  logic [31:0] jr_r31;
  logic [31:0] exp_same_cycle;

  initial begin
    addiu_r2_5 = i_ins(6'b001001, 5'd0, 5'd2, 16'd5);
    jr_r31     = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000);

    // Reset state
    reset = 1; insn = j_ins(6'b000011, 26'h0008004); stall = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    clear_byp();
    tick();
    tick();
    check("rst_pc", pc_fd, 32'h80020000);
    check("rst_iaddr", i_address, 32'h80020000);
    check("rst_ir_dx", ir_dx, 32'h0);
    check("rst_ctl_dx", 32'(ctl_dx), 32'h0);
    check("rst_do_branch", 32'(do_branch), 32'h0);
    check("rst_imem_en", 32'(i_mem_enable), 32'h0);
    reset = 0; insn = 0;
    #1;
    check("imem_en", 32'(i_mem_enable), 32'h1);
    check("imem_rw", 32'(i_rw), 32'h1);
    check("imem_size", 32'(i_access_size), 32'h0);
    check("pc_0", pc_fd, 32'h80020000);

    // Register file reset values through ADDU rd, rX, r0
    insn = r_ins(5'd29, 5'd0, 5'd1, 5'd0, 6'b100001);
    tick();
    check("pc_1", pc_fd, 32'h80020004);
    check("r29_init", alu_out, 32'h80120000);
    insn = r_ins(5'd31, 5'd0, 5'd1, 5'd0, 6'b100001);
    tick();
    check("pc_2", pc_fd, 32'h80020008);
    check("iaddr_2", i_address, 32'h80020008);
    check("r31_init", alu_out, 32'hdeadbeef);

    insn = addiu_r2_5;
    tick();
    check("addiu", alu_out, 32'h5);
    check("addiu_ctl", 32'(ctl_dx), 32'h28);

    // ADDU r3,r2,r2 with bypass variants
    insn = r_ins(5'd2, 5'd2, 5'd3, 5'd0, 6'b100001);
    tick();
    check("addu_nobyp", alu_out, 32'h0);
    check("addu_ctl", 32'(ctl_dx), 32'h0c);
    byp_mx_a = 1; byp_mx_b = 1; mx_data = 32'd5;
    #1;
    check("addu_mx", alu_out, 32'd10);
    check("rb_mx", rb_out, 32'd5);
    byp_mx_a = 0; byp_wx_a = 1; wx_data = 32'd7;
    #1;
    check("addu_wx_a", alu_out, 32'd12);
    byp_mx_a = 1;
    #1;
    check("addu_mx_wins", alu_out, 32'd10);
    clear_byp();

    insn = r_ins(5'd0, 5'd2, 5'd1, 5'd4, 6'b000011);
    tick();
    byp_mx_b = 1; mx_data = 32'h80000000;
    #1;
    check("sra", alu_out, 32'hf8000000);
    clear_byp();

    insn = i_ins(6'b001111, 5'd0, 5'd1, 16'h1234);
    tick();
    check("lui", alu_out, 32'h12340000);
    insn = i_ins(6'b001101, 5'd0, 5'd1, 16'h8000);
    tick();
    check("ori_zext", alu_out, 32'h00008000);
    insn = i_ins(6'b001001, 5'd0, 5'd1, 16'h8000);
    tick();
    check("addiu_sext", alu_out, 32'hffff8000);

    insn = i_ins(6'b101011, 5'd0, 5'd2, 16'd8);
    tick();
    byp_mx_a = 1; mx_data = 32'h100; byp_wx_b = 1; wx_data = 32'hcafef00d;
    #1;
    check("sw_addr", alu_out, 32'h108);
    check("sw_data", rb_out, 32'hcafef00d);
    check("sw_ctl", 32'(ctl_dx), 32'h30);
    clear_byp();

    insn = 32'hfc000000;
    tick();
    check("unk_ctl", 32'(ctl_dx), 32'h0);
    check("unk_nobr", 32'(do_branch), 32'h0);

    insn = i_ins(6'b000101, 5'd0, 5'd0, 16'd3);
    tick();
    check("bne_not_taken", 32'(do_branch), 32'h0);
    insn = i_ins(6'b000111, 5'd1, 5'd0, 16'd1);
    byp_mx_a = 1; mx_data = 32'hffffffff;
    tick();
    check("bgtz_neg", 32'(do_branch), 32'h0);
    insn = i_ins(6'b000001, 5'd1, 5'd0, 16'd1);
    tick();
    check("bltz_neg", 32'(do_branch), 32'h1);
    clear_byp();

    // Branch redirect, squash and stall
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("pc_before_beq", pc_fd, 32'h80020010);
    insn = i_ins(6'b000100, 5'd0, 5'd0, 16'd3);
    tick();
    check("beq_pc_fd", pc_fd, 32'h80020014);
    check("beq_taken", 32'(do_branch), 32'h1);
    check("beq_target", pc_effective, 32'h80020020);
    insn = addiu_r2_5;
    tick();
    check("redirect_pc", pc_fd, 32'h80020020);
    check("squash_ir", ir_dx, 32'h0);
    check("squash_nobr", 32'(do_branch), 32'h0);
    stall = 1;
    tick();
    check("stall_pc_hold", pc_fd, 32'h80020020);
    check("stall_bubble", ir_dx, 32'h0);
    stall = 0;
    tick();
    check("resume_pc", pc_fd, 32'h80020024);
    check("resume_ir", ir_dx, addiu_r2_5);
    insn = i_ins(6'b000100, 5'd0, 5'd0, 16'hfffe);
    tick();
    check("beq_back_target", pc_effective, 32'h80020020);
    check("beq_back_taken", 32'(do_branch), 32'h1);
    stall = 1;
    tick();
    check("branch_over_stall", pc_fd, 32'h80020020);
    check("branch_stall_ir", ir_dx, 32'h0);
    stall = 0;

    // JAL then JR r31
    do_reset();
    insn = j_ins(6'b000011, 26'h0008004);
    tick();
    check("jal_taken", 32'(do_branch), 32'h1);
    check("jal_target", pc_effective, 32'h80020010);
    check("jal_link", alu_out, 32'h80020008);
    check("jal_ctl", 32'(ctl_dx), 32'h48);
    insn = jr_r31;
    tick();
    check("jal_redirect", pc_fd, 32'h80020010);
    check("jal_squash", ir_dx, 32'h0);
    tick();
    check("jr_ir", ir_dx, jr_r31);
    check("jr_taken", 32'(do_branch), 32'h1);
    check("jr_target", pc_effective, 32'hdeadbeef);

    // Register-file writes
    do_reset();
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hffffffff;
    insn = r_ins(5'd0, 5'd0, 5'd1, 5'd0, 6'b100001);
    tick();
    check("r0_write_ignored", alu_out, 32'h0);
    wb_rd = 5'd5;
    insn = r_ins(5'd5, 5'd0, 5'd1, 5'd0, 6'b100001);
    tick();
`ifdef REGFILE_WRITE_THROUGH_EN
    exp_same_cycle = 32'hffffffff;
`else
    exp_same_cycle = 32'h0;
`endif
    check("r5_same_cycle", alu_out, exp_same_cycle);
    wb_we = 0; wb_rd = 5'd0; wb_data = 32'h0;
    tick();
    check("r5_written", alu_out, 32'hffffffff);
    insn = r_ins(5'd0, 5'd0, 5'd1, 5'd0, 6'b100001);
    tick();
    check("r0_reads_zero", alu_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fdx_frontend.md
Name: mips_fdx_frontend

Overview:
- Front three stages of the 5-stage MIPS pipeline: fetch (PC/IMEM request), decode (control plus 32x32 register file) and execute (ALU, branch/jump resolution, MX/WX bypass muxes).
- Includes the D/X pipeline register.
- Drives the external instruction memory; the X/M stage consumes its outputs; writeback returns results through the register-file write port.

Parameters:
- BASE_ADDR, 32'h80020000, PC value after reset.
- SP_INIT, 32'h80120000, r29 value after reset.
- RA_INIT, 32'hdeadbeef, r31 value after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- i_address  out  32  IMEM address; always equals pc_fd.
- i_mem_enable  out  1  IMEM enable; 1 when not in reset.
- i_rw  out  1  IMEM rw; constant 1 (read).
- i_access_size  out  2  constant 2'b00 (word).
- insn  in  32  IMEM read data for i_address, valid in the same cycle.
- stall  in  1  load-use stall from the hazard unit.
- pc_fd  out  32  PC of the instruction in F/D.
- wb_we  in  1  register-file write enable.
- wb_rd  in  5  register-file write index.
- wb_data  in  32  register-file write data.
- mx_data  in  32  X/M ALU result used for bypass.
- wx_data  in  32  writeback data used for bypass.
- byp_mx_a, byp_wx_a, byp_mx_b, byp_wx_b  in  1 each  bypass selects.
- ir_dx  out  32  D/X instruction.
- ctl_dx  out  8  D/X control, bit order {br,jp,aluinb,dmwe,rwe,rdst,rwd,dm_byte}.
- alu_out  out  32  execute result or memory address.
- rb_out  out  32  store data after bypass.
- pc_effective  out  32  branch/jump target.
- do_branch  out  1  taken branch or jump this cycle.

Behaviour:
- Reset:
  - pc_fd = BASE_ADDR.
  - D/X cleared: ir_dx = 0, ctl_dx = 0, aluop = NOP (6'b100001).
  - Register file all zero, except r29 = SP_INIT and r31 = RA_INIT.
  - While reset is held, do_branch = 0.
- Fetch, each clock:
  - if do_branch, pc <= pc_effective;
  - else if stall, pc holds;
  - else pc <= pc + 4.
  - do_branch has priority over stall.
- Decode (combinational on insn):
  - rA = R[rs], rB = R[rt]; r0 always reads 0.
  - Control signals:
    - rdst = 1 for R-type.
    - aluinb = 1 for immediate forms.
    - rwe = 1 for ALU, LW, LB, LUI and JAL.
    - dmwe = 1 for SW and SB.
    - rwd = 1 for loads.
    - dm_byte = 1 for LB and SB.
    - br = 1 for BEQ, BNE, BLEZ, BGTZ, BLTZ and BGEZ.
    - jp = 1 for J, JAL and JR.
    - Unknown opcodes decode as NOP (all control 0).
- Supported instructions: ADDU, ADD, SUBU, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, ADDIU, ADDI, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, LB, SB, the branches above, J, JAL, JR, NOP.
  - ADD, SUB and ADDI ignore overflow.
- Register write: on the rising edge when wb_we = 1 and wb_rd != 0.
  - Reads in that same cycle return the old value (see Optional Feature).
- D/X register: on each edge it captures pc, insn, rA, rB and control.
  - If stall or do_branch is 1 it loads a bubble instead: all zero, aluop = NOP.
- Execute (combinational from D/X):
  - Operand A = byp_mx_a ? mx_data : byp_wx_a ? wx_data : rA_dx; MX wins over WX.
  - Operand B is muxed the same way with the _b selects.
  - ALU B input = aluinb ? immediate : operand B.
    - Immediates are sign-extended, except ANDI, ORI and XORI, which are zero-extended.
  - Load/store: alu_out = A + sext(imm16).
  - rb_out = operand B after bypass.
  - LUI: alu_out = imm16 << 16.
  - JAL: alu_out = pc_dx + 8; destination r31.
- Branch targets:
  - Branch target = pc_dx + 4 + (sext(imm16) << 2); comparisons are signed.
  - J/JAL target = {pc_dx[31:28], imm26, 2'b00}.
  - JR target = operand A.
  - do_branch = jp | (br & condition true).
  - No delay slot: the F/D instruction is squashed by the D/X bubble.

Optional Feature:
- Macro REGFILE_WRITE_THROUGH_EN.
- Defined: a decode read of a register being written this cycle (wb_we = 1, index match, index != 0) returns wb_data.
- Undefined: the read returns the stored old value.

Test Plan:
- Reset, then release → pc_fd = 80020000, 80020004, 80020008 on successive cycles; R[29] = SP_INIT, R[31] = deadbeef.
- ADDIU r2,r0,5 then ADDU r3,r2,r2 with byp_mx_a = byp_mx_b = 1 and mx_data = 5 → alu_out = 10.
- BEQ r0,r0,+3 at PC 80020010 → do_branch = 1, pc_effective = 80020020; next D/X is a bubble (ir_dx = 0).
- Assert stall for 1 cycle → pc_fd holds, D/X receives a bubble, fetch resumes next cycle.
- JAL 0x0008004 at PC 80020000 → pc_effective = 80020010, alu_out = 80020008.
- wb_we = 1, wb_rd = 0, wb_data = ffffffff → R0 still reads 0; wb_rd = 5 → R5 = ffffffff on the next read.
